// File: rtl/dilithium_load_sequencer.sv
// rtl/dilithium_load_sequencer.sv - operand load sequencer for one Dilithium KEYGEN/SIGN/VERIFY job
//
// Takes one W-bit source word stream and passes it to the core. Each word is
// tagged with the segment it belongs to. The segment order and the segment
// sizes are set by the mode, SEC_LEVEL and the message length. The MSGLEN word
// is generated here and takes no word from the source.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   start_i, mode_i, msg_len_i job request (start is a pulse, sampled in IDLE)
//   busy_o, done_o, err_o      job status (done/err are 1-cycle pulses)
//   in_data_i/in_valid_i/in_ready_o     source word stream
//   out_data_o/out_valid_o/out_ready_i  word stream to the core
//   seg_id_o, seg_last_o, pkt_last_o    tags for the current output word
module dilithium_load_sequencer #(
  parameter int W         = 64,
  parameter int SEC_LEVEL = 2,
  parameter int MSG_LEN_W = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [MSG_LEN_W-1:0] msg_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [W-1:0]         in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [W-1:0]         out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [3:0]           seg_id_o,
  output logic                 seg_last_o,
  output logic                 pkt_last_o
);

  localparam int S1_BITS = (SEC_LEVEL == 2) ? 3072  : (SEC_LEVEL == 3) ? 5120  : 5376;
  localparam int S2_BITS = (SEC_LEVEL == 2) ? 3072  : 6144;
  localparam int T1_BITS = (SEC_LEVEL == 2) ? 10240 : (SEC_LEVEL == 3) ? 15360 : 20480;
  localparam int T0_BITS = (SEC_LEVEL == 2) ? 13312 : (SEC_LEVEL == 3) ? 19968 : 26624;
  localparam int Z_BITS  = (SEC_LEVEL == 2) ? 18432 : (SEC_LEVEL == 3) ? 25600 : 35840;
  localparam int H_BITS  = (SEC_LEVEL == 2) ? 672   : (SEC_LEVEL == 3) ? 488   : 664;

  localparam logic [15:0] SMALL_WORDS = 16'((256 + W - 1) / W);
  localparam logic [15:0] S1_WORDS    = 16'((S1_BITS + W - 1) / W);
  localparam logic [15:0] S2_WORDS    = 16'((S2_BITS + W - 1) / W);
  localparam logic [15:0] T1_WORDS    = 16'((T1_BITS + W - 1) / W);
  localparam logic [15:0] T0_WORDS    = 16'((T0_BITS + W - 1) / W);
  localparam logic [15:0] Z_WORDS     = 16'((Z_BITS + W - 1) / W);
  localparam logic [15:0] H_WORDS     = 16'((H_BITS + W - 1) / W);

  localparam logic [3:0] SEG_SEED = 4'd0, SEG_RHO = 4'd1, SEG_KEY = 4'd2, SEG_TR = 4'd3,
                         SEG_C = 4'd4, SEG_MSGLEN = 4'd5, SEG_MSG = 4'd6, SEG_S1 = 4'd7,
                         SEG_S2 = 4'd8, SEG_T0 = 4'd9, SEG_T1 = 4'd10, SEG_Z = 4'd11,
                         SEG_H = 4'd12;

  localparam logic [1:0] MODE_KEYGEN = 2'b00, MODE_VERIFY = 2'b01,
                         MODE_SIGN = 2'b10, MODE_ILLEGAL = 2'b11;

  typedef enum logic {IDLE, STREAM} state_t;

  // Segment at position idx of the job order for mode m.
  function automatic logic [3:0] seg_at(input logic [1:0] m, input logic [3:0] idx);
    logic [3:0] id;
    id = SEG_SEED;
    case (m)
      MODE_SIGN: begin
        case (idx)
          4'd0: id = SEG_RHO;
          4'd1: id = SEG_KEY;
          4'd2: id = SEG_TR;
          4'd3: id = SEG_MSGLEN;
          4'd4: id = SEG_MSG;
          4'd5: id = SEG_S1;
          4'd6: id = SEG_S2;
          4'd7: id = SEG_T0;
          default: id = SEG_SEED;
        endcase
      end
      MODE_VERIFY: begin
        case (idx)
          4'd0: id = SEG_RHO;
          4'd1: id = SEG_C;
          4'd2: id = SEG_Z;
          4'd3: id = SEG_H;
          4'd4: id = SEG_T1;
          4'd5: id = SEG_MSGLEN;
          4'd6: id = SEG_MSG;
          default: id = SEG_SEED;
        endcase
      end
      default: id = SEG_SEED;
    endcase
    return id;
  endfunction

  function automatic logic [3:0] seg_count(input logic [1:0] m);
    case (m)
      MODE_SIGN:   return 4'd8;
      MODE_VERIFY: return 4'd7;
      default:     return 4'd1;
    endcase
  endfunction

  function automatic logic [15:0] seg_words(input logic [3:0] id, input logic [15:0] msgw);
    case (id)
      SEG_MSGLEN: return 16'd1;
      SEG_MSG:    return msgw;
      SEG_S1:     return S1_WORDS;
      SEG_S2:     return S2_WORDS;
      SEG_T0:     return T0_WORDS;
      SEG_T1:     return T1_WORDS;
      SEG_Z:      return Z_WORDS;
      SEG_H:      return H_WORDS;
      default:    return SMALL_WORDS;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [MSG_LEN_W-1:0] len_q, len_d;
  logic [15:0]          msgw_q, msgw_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [MSG_LEN_W:0]   len_round;
  logic [15:0]          msgw_calc;
  logic [3:0]           cur_id, ptr_inc, ptr_next;
  logic [15:0]          cur_len;
  logic                 is_len, seg_last, pkt_last, hs;

  // Message word count is computed once, from the msg_len_i sampled at start.
  assign len_round = {1'b0, msg_len_i} + (MSG_LEN_W+1)'(W - 1);
  assign msgw_calc = 16'(len_round / (MSG_LEN_W+1)'(W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_KEYGEN;
      len_q   <= '0;
      msgw_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      msgw_q  <= msgw_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    msgw_d  = msgw_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    out_data_o  = '0;
    out_valid_o = 1'b0;
    in_ready_o  = 1'b0;
    seg_id_o    = 4'd0;
    seg_last_o  = 1'b0;
    pkt_last_o  = 1'b0;

    cur_id  = seg_at(mode_q, ptr_q);
    cur_len = seg_words(cur_id, msgw_q);
    is_len  = (cur_id == SEG_MSGLEN);
    ptr_inc = ptr_q + 4'd1;
    // An empty MSG segment is stepped over so it never appears on the output.
    if (seg_at(mode_q, ptr_inc) == SEG_MSG && msgw_q == 16'd0 && ptr_inc < seg_count(mode_q))
      ptr_next = ptr_q + 4'd2;
    else
      ptr_next = ptr_inc;
    seg_last = (cnt_q == cur_len - 16'd1);
    pkt_last = seg_last && (ptr_next >= seg_count(mode_q));
    hs       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (mode_i == MODE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            state_d = STREAM;
            mode_d  = mode_i;
            len_d   = msg_len_i;
            msgw_d  = msgw_calc;
            ptr_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      STREAM: begin
        seg_id_o   = cur_id;
        seg_last_o = seg_last;
        pkt_last_o = pkt_last;
        if (is_len) begin
          out_data_o  = {{(W-MSG_LEN_W){1'b0}}, len_q};
          out_valid_o = 1'b1;
          in_ready_o  = 1'b0;
        end else begin
          out_data_o  = in_data_i;
          out_valid_o = in_valid_i;
          in_ready_o  = out_ready_i;
        end
        hs = out_valid_o & out_ready_i;
        if (hs) begin
          if (pkt_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            ptr_d   = '0;
          end else if (seg_last) begin
            cnt_d = '0;
            ptr_d = ptr_next;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == STREAM);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dilithium_load_sequencer.sv
// tb/tb_dilithium_load_sequencer.sv - self-checking bench for dilithium_load_sequencer
module tb_dilithium_load_sequencer;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst_n, start, sel3;
  logic [1:0]  mode;
  logic [14:0] msg_len;
  logic [63:0] in_data;
  logic        in_valid, out_ready;
  logic [31:0] src_idx = 32'd0;

  logic        busy2, done2, err2, ir2, ov2, sl2, pl2;
  logic        busy3, done3, err3, ir3, ov3, sl3, pl3;
  logic [63:0] od2, od3;
  logic [3:0]  sid2, sid3;

  logic        busy, done, err, in_ready, out_valid, seg_last, pkt_last;
  logic [63:0] out_data;
  logic [3:0]  seg_id;

  always #5 clk = ~clk;

  dilithium_load_sequencer #(.W(W), .SEC_LEVEL(2), .MSG_LEN_W(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start & ~sel3), .mode_i(mode), .msg_len_i(msg_len),
    .busy_o(busy2), .done_o(done2), .err_o(err2),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(ir2),
    .out_data_o(od2), .out_valid_o(ov2), .out_ready_i(out_ready),
    .seg_id_o(sid2), .seg_last_o(sl2), .pkt_last_o(pl2)
  );

  dilithium_load_sequencer #(.W(W), .SEC_LEVEL(3), .MSG_LEN_W(15)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start & sel3), .mode_i(mode), .msg_len_i(msg_len),
    .busy_o(busy3), .done_o(done3), .err_o(err3),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(ir3),
    .out_data_o(od3), .out_valid_o(ov3), .out_ready_i(out_ready),
    .seg_id_o(sid3), .seg_last_o(sl3), .pkt_last_o(pl3)
  );

  assign busy      = sel3 ? busy3 : busy2;
  assign done      = sel3 ? done3 : done2;
  assign err       = sel3 ? err3  : err2;
  assign in_ready  = sel3 ? ir3   : ir2;
  assign out_valid = sel3 ? ov3   : ov2;
  assign out_data  = sel3 ? od3   : od2;
  assign seg_id    = sel3 ? sid3  : sid2;
  assign seg_last  = sel3 ? sl3   : sl2;
  assign pkt_last  = sel3 ? pl3   : pl2;

  // Source word k carries a recognisable pattern so any skipped or
  // duplicated source consumption shows up in the data.
  assign in_data = 64'hA5A5_0000_0000_0000 | 64'(src_idx);

  always @(posedge clk)
    if (in_valid && in_ready) src_idx <= src_idx + 32'd1;

  typedef struct {
    logic [3:0]  id;
    bit          sl;
    bit          pl;
    bit          len;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   hs_count = 0;
  bit   chk_en = 1'b0;
  bit   exp_done_now = 1'b0;
  bit   job_finished = 1'b0;
  int   model_src;

  // Expected word list from segment order and sizes.
  task automatic push_seg(input logic [3:0] id, input int n, input int len);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.id  = id;
      e.sl  = (i == n - 1);
      e.pl  = 1'b0;
      e.len = (id == 4'd5);
      if (e.len) e.data = 64'(len);
      else begin
        e.data = 64'hA5A5_0000_0000_0000 | 64'(model_src);
        model_src++;
      end
      q.push_back(e);
    end
  endtask

  task automatic build_model(input logic [1:0] m, input int len, input int lvl);
    int s1, s2, t1, t0, z, h, mw;
    exp_t e;
    case (lvl)
      2:       begin s1 = 3072; s2 = 3072; t1 = 10240; t0 = 13312; z = 18432; h = 672; end
      3:       begin s1 = 5120; s2 = 6144; t1 = 15360; t0 = 19968; z = 25600; h = 488; end
      default: begin s1 = 5376; s2 = 6144; t1 = 20480; t0 = 26624; z = 35840; h = 664; end
    endcase
    mw = (len + W - 1) / W;
    q.delete();
    model_src = int'(src_idx);
    case (m)
      2'b00: push_seg(4'd0, 256 / W, len);
      2'b10: begin
        push_seg(4'd1, 256 / W, len); push_seg(4'd2, 256 / W, len);
        push_seg(4'd3, 256 / W, len); push_seg(4'd5, 1, len);
        push_seg(4'd6, mw, len);      push_seg(4'd7, (s1 + W - 1) / W, len);
        push_seg(4'd8, (s2 + W - 1) / W, len); push_seg(4'd9, (t0 + W - 1) / W, len);
      end
      default: begin
        push_seg(4'd1, 256 / W, len); push_seg(4'd4, 256 / W, len);
        push_seg(4'd11, (z + W - 1) / W, len); push_seg(4'd12, (h + W - 1) / W, len);
        push_seg(4'd10, (t1 + W - 1) / W, len); push_seg(4'd5, 1, len);
        push_seg(4'd6, mw, len);
      end
    endcase
    e = q.pop_back();
    e.pl = 1'b1;
    q.push_back(e);
  endtask

  task automatic pin(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Compare process: every handshake against the model, and done timing.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_done_now) begin
        vectors++;
        if (!(done && !busy)) begin
          miscompares++;
          $display("FAIL done_pulse: done=%0b busy=%0b expected done=1 busy=0", done, busy);
        end
        job_finished = 1'b1;
      end else if (done) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: done=1 expected 0");
      end
      exp_done_now = 1'b0;
      if (out_valid && out_ready) begin
        hs_count++;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word: seg=%0d data=%h with no word expected", seg_id, out_data);
        end else begin
          e = q.pop_front();
          if (seg_id != e.id || seg_last != e.sl || pkt_last != e.pl || out_data != e.data ||
              (e.len && in_ready)) begin
            miscompares++;
            $display("FAIL word%0d: seg=%0d sl=%0b pl=%0b data=%h rdy=%0b expected seg=%0d sl=%0b pl=%0b data=%h",
                     hs_count, seg_id, seg_last, pkt_last, out_data, in_ready, e.id, e.sl, e.pl, e.data);
          end
          if (e.pl) exp_done_now = 1'b1;
        end
      end
    end
  end

  task automatic check_idle(input string name);
    vectors++;
    if (busy || done || err || out_valid || in_ready || seg_id != 4'd0 || out_data != 64'd0) begin
      miscompares++;
      $display("FAIL %s: busy=%0b done=%0b err=%0b ov=%0b ir=%0b seg=%0d data=%h expected all 0",
               name, busy, done, err, out_valid, in_ready, seg_id, out_data);
    end
  endtask

  task automatic run_job(input logic [1:0] m, input int len, input int lvl, input bit throttle,
                         input int abort_at, input int busy_start);
    int cyc;
    build_model(m, len, lvl);
    hs_count = 0;
    job_finished = 1'b0;
    @(posedge clk); #1;
    sel3 = (lvl == 3);
    mode = m;
    msg_len = 15'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (!busy) begin
      miscompares++;
      $display("FAIL busy_after_start: busy=0 expected 1");
    end
    cyc = 0;
    while (!job_finished && cyc < 20000) begin
      if (throttle) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
      end
      if (cyc == busy_start) begin
        start = 1'b1;
        mode = 2'b00;
        msg_len = 15'h7fff;
      end else begin
        start = 1'b0;
      end
      if (abort_at > 0 && hs_count >= abort_at) begin
        chk_en = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        q.delete();
        exp_done_now = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("idle_after_abort");
        chk_en = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!job_finished) begin
      vectors++;
      miscompares++;
      $display("FAIL job_timeout: no done after %0d cycles", cyc);
    end
    pin("words_left", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel3 = 1'b0;
    mode = 2'b00;
    msg_len = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle("reset_state");
    chk_en = 1'b1;

    // Hand-computed word lists pinning the model.
    build_model(2'b00, 0, 2);
    pin("keygen_words", q.size(), 4);
    build_model(2'b01, 264, 2);
    pin("verify_words", q.size(), 473);
    pin("verify_msglen_id", int'(q[467].id), 5);
    pin("verify_msglen_val", int'(q[467].data), 32'h108);
    pin("verify_last_id", int'(q[472].id), 6);
    build_model(2'b10, 0, 2);
    pin("sign0_words", q.size(), 317);
    pin("sign0_last_id", int'(q[316].id), 9);
    pin("sign0_last_pl", int'(q[316].pl), 1);
    build_model(2'b10, 8000, 3);
    pin("sign_l3_words", q.size(), 626);
    q.delete();

    run_job(2'b00, 0, 2, 1'b0, 0, -1);
    run_job(2'b01, 264, 2, 1'b0, 0, 50);
    run_job(2'b10, 0, 2, 1'b0, 0, -1);
    run_job(2'b10, 8000, 3, 1'b0, 0, -1);
    run_job(2'b10, 8000, 3, 1'b1, 0, 300);
    run_job(2'b10, 200, 2, 1'b1, 0, -1);

    // Illegal mode.
    @(posedge clk); #1;
    sel3 = 1'b0;
    mode = 2'b11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (!err || busy) begin
      miscompares++;
      $display("FAIL err_pulse: err=%0b busy=%0b expected err=1 busy=0", err, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (err || busy) begin
      miscompares++;
      $display("FAIL err_one_cycle: err=%0b busy=%0b expected 0 0", err, busy);
    end

    // Abort mid-job, then a clean KEYGEN.
    run_job(2'b01, 264, 2, 1'b0, 100, -1);
    run_job(2'b00, 0, 2, 1'b0, 0, -1);
    @(posedge clk); #1;
    check_idle("idle_at_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
